day_of_year_tracker: RTL and testbench

Sequential calendar counter. Holds the current date (day of month, month, year) and the matching day of the year, and advances it one day per tick strobe. Handles leap years. Accepts a validated date load. Provides the clocked date source for the calendar/timestamp logic that today uses the combinational day-of-year calculator.

---
 rtl/day_of_year_tracker.sv | 178 +++++++++++++++++
 tb/tb_day_of_year_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/day_of_year_tracker.sv
// Sequential calendar counter: day of month, month, year and day of year,
// advanced by a one-day tick strobe or set by a validated date load.
// Optional macro GREGORIAN_CENTURY_EN: full Gregorian leap rule (century
// years are leap only when divisible by 400); undefined = divisible-by-4 rule.
module day_of_year_tracker #(
  parameter int YEAR_W     = 12,
  parameter int RESET_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              loadValid,
  input  logic [5:0]        loadDay,
  input  logic [3:0]        loadMonth,
  input  logic [YEAR_W-1:0] loadYear,
  output logic [5:0]        dayOfMonth,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [8:0]        dayOfYear,
  output logic              isLeap,
  output logic              yearWrap,
  output logic              loadErr
);

  localparam logic [YEAR_W-1:0] YEAR_ONE = {{(YEAR_W-1){1'b0}}, 1'b1};

  // Days in month m; February depends on the leap flag.
  function automatic logic [5:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                        month_len = lp ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:     month_len = 6'd30;
      default:                     month_len = 6'd31;
    endcase
  endfunction

  // Days in the non-leap year preceding the first of month m.
  function automatic logic [8:0] days_before(input logic [3:0] m);
    case (m)
      4'd2:    days_before = 9'd31;
      4'd3:    days_before = 9'd59;
      4'd4:    days_before = 9'd90;
      4'd5:    days_before = 9'd120;
      4'd6:    days_before = 9'd151;
      4'd7:    days_before = 9'd181;
      4'd8:    days_before = 9'd212;
      4'd9:    days_before = 9'd243;
      4'd10:   days_before = 9'd273;
      4'd11:   days_before = 9'd304;
      4'd12:   days_before = 9'd334;
      default: days_before = 9'd0;
    endcase
  endfunction

`ifdef GREGORIAN_CENTURY_EN
  // Leap from the year's residues mod 100 and mod 400 (mod 400 also gives mod 4).
  function automatic logic greg_leap(input logic [6:0] m100, input logic [8:0] m400);
    greg_leap = ((m400[1:0] == 2'b00) && (m100 != 7'd0)) || (m400 == 9'd0);
  endfunction

  localparam logic [6:0] RESET_M100 = 7'(RESET_YEAR % 100);
  localparam logic [8:0] RESET_M400 = 9'(RESET_YEAR % 400);
  localparam logic       RESET_LEAP = ((RESET_YEAR % 4 == 0) && (RESET_YEAR % 100 != 0))
                                      || (RESET_YEAR % 400 == 0);

  logic [6:0] m100_reg;
  logic [8:0] m400_reg;
  logic [6:0] ld_m100, inc_m100;
  logic [8:0] ld_m400, inc_m400;
`else
  localparam logic RESET_LEAP = (RESET_YEAR % 4 == 0);
`endif

  logic [5:0]        day_reg;
  logic [3:0]        month_reg;
  logic [YEAR_W-1:0] year_reg;
  logic [8:0]        doy_reg;
  logic              leap_reg;
  logic              year_wrap_reg;
  logic              load_err_reg;

  logic              ld_leap, ld_ok;
  logic [8:0]        ld_doy;
  logic              end_of_month, last_day;
  logic [YEAR_W-1:0] year_inc;
  logic              inc_leap;

  // Load validation, load day-of-year and next-year leap status.
  always_comb begin
    year_inc = year_reg + YEAR_ONE;
`ifdef GREGORIAN_CENTURY_EN
    ld_m100 = 7'(32'(loadYear) % 32'd100);
    ld_m400 = 9'(32'(loadYear) % 32'd400);
    if (year_inc == '0) begin
      // Year counter wrapped to 0, which is a multiple of both 100 and 400.
      inc_m100 = 7'd0;
      inc_m400 = 9'd0;
    end else begin
      inc_m100 = (m100_reg == 7'd99)  ? 7'd0 : m100_reg + 7'd1;
      inc_m400 = (m400_reg == 9'd399) ? 9'd0 : m400_reg + 9'd1;
    end
    ld_leap  = greg_leap(ld_m100, ld_m400);
    inc_leap = greg_leap(inc_m100, inc_m400);
`else
    ld_leap  = (loadYear[1:0] == 2'b00);
    inc_leap = (year_inc[1:0] == 2'b00);
`endif
    ld_ok = (loadMonth >= 4'd1) && (loadMonth <= 4'd12) &&
            (loadDay >= 6'd1) && (loadDay <= month_len(loadMonth, ld_leap));
    ld_doy = days_before(loadMonth) + {3'b000, loadDay} +
             ((ld_leap && (loadMonth > 4'd2)) ? 9'd1 : 9'd0);
    end_of_month = (day_reg == month_len(month_reg, leap_reg));
    last_day     = end_of_month && (month_reg == 4'd12);
  end

  // Date state: load has priority over tick; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_reg       <= 6'd1;
      month_reg     <= 4'd1;
      year_reg      <= YEAR_W'(RESET_YEAR);
      doy_reg       <= 9'd1;
      leap_reg      <= RESET_LEAP;
      year_wrap_reg <= 1'b0;
      load_err_reg  <= 1'b0;
`ifdef GREGORIAN_CENTURY_EN
      m100_reg      <= RESET_M100;
      m400_reg      <= RESET_M400;
`endif
    end else begin
      year_wrap_reg <= 1'b0;
      load_err_reg  <= 1'b0;
      if (loadValid) begin
        if (ld_ok) begin
          day_reg   <= loadDay;
          month_reg <= loadMonth;
          year_reg  <= loadYear;
          doy_reg   <= ld_doy;
          leap_reg  <= ld_leap;
`ifdef GREGORIAN_CENTURY_EN
          m100_reg  <= ld_m100;
          m400_reg  <= ld_m400;
`endif
        end else begin
          load_err_reg <= 1'b1;
        end
      end else if (tick) begin
        if (last_day) begin
          day_reg       <= 6'd1;
          month_reg     <= 4'd1;
          year_reg      <= year_inc;
          doy_reg       <= 9'd1;
          leap_reg      <= inc_leap;
          year_wrap_reg <= 1'b1;
`ifdef GREGORIAN_CENTURY_EN
          m100_reg      <= inc_m100;
          m400_reg      <= inc_m400;
`endif
        end else if (end_of_month) begin
          day_reg   <= 6'd1;
          month_reg <= month_reg + 4'd1;
          doy_reg   <= doy_reg + 9'd1;
        end else begin
          day_reg <= day_reg + 6'd1;
          doy_reg <= doy_reg + 9'd1;
        end
      end
    end
  end

  assign dayOfMonth = day_reg;
  assign month      = month_reg;
  assign year       = year_reg;
  assign dayOfYear  = doy_reg;
  assign isLeap     = leap_reg;
  assign yearWrap   = year_wrap_reg;
  assign loadErr    = load_err_reg;

endmodule

// File: tb/tb_day_of_year_tracker.sv
// Self-checking bench: a 12-bit-year instance and a 4-bit-year instance share
// the stimulus and are compared every cycle against a calendar model.
module tb_day_of_year_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        load_valid = 1'b0;
  logic [5:0]  load_day = 6'd0;
  logic [3:0]  load_month = 4'd0;
  logic [11:0] load_year = 12'd0;
  logic [3:0]  load_year_s;

  logic [5:0]  b_dom, s_dom;
  logic [3:0]  b_mon, s_mon;
  logic [11:0] b_year;
  logic [3:0]  s_year;
  logic [8:0]  b_doy, s_doy;
  logic        b_leap, s_leap, b_wrap, s_wrap, b_err, s_err;

  int n_checks = 0;
  int n_pass   = 0;

  assign load_year_s = load_year[3:0];

  always #5 clk = ~clk;

  day_of_year_tracker #(.YEAR_W(12), .RESET_YEAR(2000)) dut_big (
    .clk(clk), .rst_n(rst_n), .tick(tick), .loadValid(load_valid),
    .loadDay(load_day), .loadMonth(load_month), .loadYear(load_year),
    .dayOfMonth(b_dom), .month(b_mon), .year(b_year), .dayOfYear(b_doy),
    .isLeap(b_leap), .yearWrap(b_wrap), .loadErr(b_err));

  day_of_year_tracker #(.YEAR_W(4), .RESET_YEAR(9)) dut_small (
    .clk(clk), .rst_n(rst_n), .tick(tick), .loadValid(load_valid),
    .loadDay(load_day), .loadMonth(load_month), .loadYear(load_year_s),
    .dayOfMonth(s_dom), .month(s_mon), .year(s_year), .dayOfYear(s_doy),
    .isLeap(s_leap), .yearWrap(s_wrap), .loadErr(s_err));

  typedef struct {
    int d; int m; int y; int wrap; int err;
  } model_t;

  model_t mb, ms;

  function automatic int mleap(int y);
`ifdef GREGORIAN_CENTURY_EN
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
    return (y % 4 == 0);
`endif
  endfunction

  function automatic int mlen(int m, int y);
    if (m == 2) return mleap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int mdoy(int d, int m, int y);
    int s = d;
    for (int i = 1; i < m; i++) s += mlen(i, y);
    return s;
  endfunction

  function automatic model_t mreset(int y);
    model_t r;
    r.d = 1; r.m = 1; r.y = y; r.wrap = 0; r.err = 0;
    return r;
  endfunction

  function automatic model_t mstep(model_t s, int ldv, int ld_d, int ld_m, int ld_y,
                                   int tk, int ymod);
    model_t n = s;
    n.wrap = 0;
    n.err  = 0;
    if (ldv != 0) begin
      if (ld_m >= 1 && ld_m <= 12 && ld_d >= 1 && ld_d <= mlen(ld_m, ld_y)) begin
        n.d = ld_d; n.m = ld_m; n.y = ld_y;
      end else begin
        n.err = 1;
      end
    end else if (tk != 0) begin
      if (s.d < mlen(s.m, s.y)) begin
        n.d = s.d + 1;
      end else if (s.m < 12) begin
        n.d = 1; n.m = s.m + 1;
      end else begin
        n.d = 1; n.m = 1; n.y = (s.y + 1) % ymod; n.wrap = 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    check("big.day",   int'(b_dom),  mb.d);
    check("big.month", int'(b_mon),  mb.m);
    check("big.year",  int'(b_year), mb.y);
    check("big.doy",   int'(b_doy),  mdoy(mb.d, mb.m, mb.y));
    check("big.leap",  int'(b_leap), mleap(mb.y));
    check("big.wrap",  int'(b_wrap), mb.wrap);
    check("big.err",   int'(b_err),  mb.err);
    check("sml.day",   int'(s_dom),  ms.d);
    check("sml.month", int'(s_mon),  ms.m);
    check("sml.year",  int'(s_year), ms.y);
    check("sml.doy",   int'(s_doy),  mdoy(ms.d, ms.m, ms.y));
    check("sml.leap",  int'(s_leap), mleap(ms.y));
    check("sml.wrap",  int'(s_wrap), ms.wrap);
    check("sml.err",   int'(s_err),  ms.err);
  endtask

  // One clock of stimulus; model advanced with the same sampled inputs.
  task automatic step(input int ldv, input int d, input int m, input int y, input int tk);
    load_valid = (ldv != 0);
    load_day   = 6'(d);
    load_month = 4'(m);
    load_year  = 12'(y);
    tick       = (tk != 0);
    @(posedge clk);
    #1;
    mb = mstep(mb, ldv, d, m, y % 4096, tk, 4096);
    ms = mstep(ms, ldv, d, m, y % 16, tk, 16);
    compare_all();
    $display("step ld=%0d %0d/%0d/%0d tick=%0d -> big %0d/%0d/%0d doy=%0d err=%0d wrap=%0d",
             ldv, m, d, y, tk, b_mon, b_dom, b_year, b_doy, b_err, b_wrap);
  endtask

  initial begin
    mb = mreset(2000);
    ms = mreset(9);
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("rst.doy", int'(b_doy), 1);
    check("rst.leap", int'(b_leap), 1);
    rst_n = 1'b1;

    // Leap-day crossing from reset.
    repeat (59) step(0, 0, 0, 0, 1);
    check("feb29.day", int'(b_dom), 29);
    check("feb29.doy", int'(b_doy), 60);
    check("feb29.leap", int'(b_leap), 1);
    step(0, 0, 0, 0, 1);
    check("mar1.month", int'(b_mon), 3);
    check("mar1.doy", int'(b_doy), 61);

    // Dec 31 rollover into a leap year.
    step(1, 31, 12, 2023, 0);
    check("dec31.doy", int'(b_doy), 365);
    step(0, 0, 0, 0, 1);
    check("ny.year", int'(b_year), 2024);
    check("ny.doy", int'(b_doy), 1);
    check("ny.wrap", int'(b_wrap), 1);
    check("ny.leap", int'(b_leap), 1);
    step(0, 0, 0, 0, 0);
    check("ny.wrap_off", int'(b_wrap), 0);

    // Rejected loads.
    step(1, 29, 2, 2023, 0);
    check("rej1.err", int'(b_err), 1);
    check("rej1.year", int'(b_year), 2024);
    step(1, 1, 13, 2024, 0);
    check("rej2.err", int'(b_err), 1);
    step(1, 31, 4, 2024, 0);
    check("rej3.err", int'(b_err), 1);
    step(0, 0, 0, 0, 0);
    check("rej.err_off", int'(b_err), 0);

    // Century leap rule.
    step(1, 29, 2, 2100, 0);
`ifdef GREGORIAN_CENTURY_EN
    check("c2100.err", int'(b_err), 1);
`else
    check("c2100.err", int'(b_err), 0);
    check("c2100.doy", int'(b_doy), 60);
`endif
    step(1, 29, 2, 2000, 0);
    check("c2000.err", int'(b_err), 0);
    check("c2000.doy", int'(b_doy), 60);

    // Load wins over a simultaneous tick.
    step(1, 15, 6, 2024, 1);
    check("prio.day", int'(b_dom), 15);
    check("prio.doy", int'(b_doy), 167);

    // 4-bit year wraps 15 -> 0.
    step(1, 31, 12, 15, 0);
    step(0, 0, 0, 0, 1);
    check("w4.year", int'(s_year), 0);
    check("w4.wrap", int'(s_wrap), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int ldv, d, m, y, tk;
      ldv = ($urandom_range(0, 99) < 4) ? 1 : 0;
      tk  = ($urandom_range(0, 99) < 80) ? 1 : 0;
      if ($urandom_range(0, 9) < 8) begin
        m = $urandom_range(1, 12);
        d = $urandom_range(1, 31);
      end else begin
        m = $urandom_range(0, 15);
        d = $urandom_range(0, 33);
      end
      if ($urandom_range(0, 3) == 0) y = 1900 + 100 * $urandom_range(0, 5);
      else y = $urandom_range(0, 4095);
      step(ldv, d, m, y, tk);
    end

    // Asynchronous reset away from any clock edge.
    repeat (5) step(0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    mb = mreset(2000);
    ms = mreset(9);
    compare_all();
    check("arst.doy", int'(b_doy), 1);
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    step(0, 0, 0, 0, 1);
    check("post_rst.day", int'(b_dom), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
